mmio_input_ctrl: RTL and testbench

Memory-mapped input peripheral for the pipelined core's I/O space. It replaces direct single-cycle register sampling of KEY and SW with four functions: two-flop synchronisation, per-bit debouncing, sticky key-press edge capture (write-1-to-clear) and a maskable interrupt request. It sits on the data-memory bus beside DataMemory and answers loads and stores decoded to its base address. Input widths, debounce length and base address are parameters.

---
 rtl/mmio_input_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mmio_input_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_input_ctrl.sv
// mmio_input_ctrl: memory-mapped KEY/SW input peripheral.
// It synchronises and debounces the raw inputs and latches sticky key-press flags
// (write-1-to-clear). It raises a maskable interrupt. Loads and stores decoded to
// BASE_ADDR are answered through a 16-byte register window.
//
// Bus handshake: rdEn and wrEn are single-cycle strobes with no back-pressure.
// - A load sampled at edge N returns data on rdData with rdValid=1 for the one
//   cycle after edge N. rdData then holds until the next load.
// - A store commits at the edge where wrEn is sampled.
// - A load and a store in the same cycle read the pre-store value.
module mmio_input_ctrl #(
    parameter int          KEY_WIDTH       = 4,
    parameter int          SW_WIDTH        = 10,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_WIDTH       = 16,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter logic [31:0] BASE_ADDR       = 32'hF0000010
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic [SW_WIDTH-1:0]  sw_in,
    input  logic [31:0]          addr,
    input  logic                 rdEn,
    input  logic                 wrEn,
    input  logic [31:0]          wrData,
    output logic                 sel,
    output logic [31:0]          rdData,
    output logic                 rdValid,
    output logic                 irq
);

    localparam int                   TOTAL    = KEY_WIDTH + SW_WIDTH;
    localparam logic [KEY_WIDTH-1:0] KEY_IDLE = {KEY_WIDTH{KEY_ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] OFF_KDATA  = 2'd0;
    localparam logic [1:0] OFF_SDATA  = 2'd1;
    localparam logic [1:0] OFF_KEDGE  = 2'd2;

    // Synchroniser and debounce state
    logic [KEY_WIDTH-1:0] keyMeta;
    logic [KEY_WIDTH-1:0] keySync;
    logic [SW_WIDTH-1:0]  swMeta;
    logic [SW_WIDTH-1:0]  swSync;
    logic [1:0]           primeSr;
    logic [KEY_WIDTH-1:0] keyLogical;

    logic [TOTAL-1:0]     syncVal;
    logic [TOTAL-1:0]     stableVal;
    logic [TOTAL-1:0]     differ;
    logic [TOTAL-1:0]     accept;
    logic [CNT_WIDTH-1:0] dbCnt [TOTAL];

    logic [KEY_WIDTH-1:0] stableKey;
    logic [SW_WIDTH-1:0]  stableSw;
    logic [KEY_WIDTH-1:0] keyArmed;
    logic [KEY_WIDTH-1:0] keyPress;

    // Register file and bus
    logic [KEY_WIDTH-1:0] kedge;
    logic [KEY_WIDTH-1:0] kimask;
    logic [KEY_WIDTH-1:0] kedgeClr;
    logic [1:0]           regOff;
    logic [31:0]          readValue;
    logic                 wrSel;
    logic                 unusedBits;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign regOff     = addr[3:2];
    assign wrSel      = wrEn && sel;
    assign unusedBits = ^{addr[1:0], wrData};

    // Two-flop synchronisers. Key flops idle at the released raw level.
    // primeSr marks when the second flop holds a real sample rather than the reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyMeta <= KEY_IDLE;
            keySync <= KEY_IDLE;
            swMeta  <= '0;
            swSync  <= '0;
            primeSr <= 2'b00;
        end else begin
            keyMeta <= key_in;
            keySync <= keyMeta;
            swMeta  <= sw_in;
            swSync  <= swMeta;
            primeSr <= {primeSr[0], 1'b1};
        end
    end

    assign keyLogical = KEY_ACTIVE_LOW ? ~keySync : keySync;
    assign syncVal    = {swSync, keyLogical};
    assign stableKey  = stableVal[KEY_WIDTH-1:0];
    assign stableSw   = stableVal[TOTAL-1:KEY_WIDTH];

    // Per-bit debounce decision: accept a new level once it has differed for the full window
    always_comb begin
        differ = syncVal ^ stableVal;
        accept = '0;
        for (int i = 0; i < TOTAL; i++) begin
            accept[i] = differ[i] && (dbCnt[i] == CNT_LAST);
        end
    end

    // Per-bit debounce counters and stable levels; any agreement restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stableVal <= '0;
            for (int i = 0; i < TOTAL; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TOTAL; i++) begin
                if (!differ[i]) begin
                    dbCnt[i] <= '0;
                end else if (accept[i]) begin
                    dbCnt[i]     <= '0;
                    stableVal[i] <= syncVal[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // A key may only flag a press once it has been seen released after reset.
    // This keeps a key held through reset from producing a spurious edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyArmed <= '0;
        end else if (primeSr[1]) begin
            keyArmed <= keyArmed | (~keyLogical & ~stableKey);
        end
    end

    assign keyPress = accept[KEY_WIDTH-1:0] & keyLogical & keyArmed;
    assign kedgeClr = (wrSel && (regOff == OFF_KEDGE)) ? wrData[KEY_WIDTH-1:0] : '0;

    // Sticky press flags and interrupt mask; a press in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kedge  <= '0;
            kimask <= '0;
        end else begin
            kedge <= (kedge & ~kedgeClr) | keyPress;
            if (wrSel && (regOff == 2'd3)) begin
                kimask <= wrData[KEY_WIDTH-1:0];
            end
        end
    end

    // Register read mux, all fields zero-extended
    always_comb begin
        readValue = '0;
        case (regOff)
            OFF_KDATA: readValue = 32'(stableKey);
            OFF_SDATA: readValue = 32'(stableSw);
            OFF_KEDGE: readValue = 32'(kedge);
            default:   readValue = 32'(kimask);
        endcase
    end

    // Registered read response and interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdData  <= '0;
            rdValid <= 1'b0;
            irq     <= 1'b0;
        end else begin
            rdValid <= rdEn;
            if (rdEn) begin
                rdData <= sel ? readValue : 32'd0;
            end
            irq <= |(kedge & kimask);
        end
    end

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Directed bench for mmio_input_ctrl with a short debounce window.
module tb_mmio_input_ctrl;

    localparam int KW = 4;
    localparam int SW = 10;
    localparam int DB = 4;
    localparam int CW = 3;

    localparam logic [31:0] A_KDATA  = 32'hF0000010;
    localparam logic [31:0] A_SDATA  = 32'hF0000014;
    localparam logic [31:0] A_KEDGE  = 32'hF0000018;
    localparam logic [31:0] A_KIMASK = 32'hF000001C;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [KW-1:0] key_in = '1;
    logic [SW-1:0] sw_in = '0;
    logic [31:0]   addr = '0;
    logic          rdEn = 1'b0;
    logic          wrEn = 1'b0;
    logic [31:0]   wrData = '0;
    logic          sel;
    logic [31:0]   rdData;
    logic          rdValid;
    logic          irq;

    int total = 0;
    int bad = 0;
    logic [31:0] lastRead = '0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } busVec_t;

    busVec_t vecs [17];
    logic [7:0] bouncePat = 8'b11001100;

    mmio_input_ctrl #(
        .KEY_WIDTH(KW), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW),
        .KEY_ACTIVE_LOW(1'b1), .BASE_ADDR(32'hF0000010)
    ) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .sw_in(sw_in),
        .addr(addr), .rdEn(rdEn), .wrEn(wrEn), .wrData(wrData),
        .sel(sel), .rdData(rdData), .rdValid(rdValid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus operation followed by an idle cycle checking that rdValid drops and rdData holds
    task automatic busOp(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input string name);
        addr = a; rdEn = rd; wrEn = wr; wrData = d;
        tick();
        rdEn = 1'b0; wrEn = 1'b0;
        if (rd) begin
            check($sformatf("%s valid", name), 32'(rdValid), 32'd1);
            check($sformatf("%s data", name), rdData, exp);
            lastRead = exp;
        end else begin
            check($sformatf("%s novalid", name), 32'(rdValid), 32'd0);
            check($sformatf("%s hold", name), rdData, lastRead);
        end
        tick();
        check($sformatf("%s valid drop", name), 32'(rdValid), 32'd0);
        check($sformatf("%s data hold", name), rdData, lastRead);
    endtask

    initial begin
        // Register-access table applied with KDATA=3, SDATA=2A5, KEDGE=3, KIMASK=0
        vecs[0]  = '{1'b1, 1'b0, A_SDATA,       32'h0,        32'h2A5};
        vecs[1]  = '{1'b1, 1'b0, A_KEDGE,       32'h0,        32'h3};
        vecs[2]  = '{1'b0, 1'b1, A_KEDGE,       32'h1,        32'h0};
        vecs[3]  = '{1'b1, 1'b0, A_KEDGE,       32'h0,        32'h2};
        vecs[4]  = '{1'b1, 1'b1, A_KEDGE,       32'h2,        32'h2};
        vecs[5]  = '{1'b1, 1'b0, A_KEDGE,       32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b1, A_KDATA,       32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, A_KDATA,       32'h0,        32'h3};
        vecs[8]  = '{1'b0, 1'b1, A_SDATA,       32'h0,        32'h0};
        vecs[9]  = '{1'b1, 1'b0, A_SDATA,       32'h0,        32'h2A5};
        vecs[10] = '{1'b0, 1'b1, A_KIMASK,      32'hFFFFFFF5, 32'h0};
        vecs[11] = '{1'b1, 1'b0, A_KIMASK,      32'h0,        32'h5};
        vecs[12] = '{1'b1, 1'b0, 32'hF0000020,  32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'hF000002C,  32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, A_KIMASK,      32'h0,        32'h5};
        vecs[15] = '{1'b0, 1'b1, A_KIMASK,      32'h0,        32'h0};
        vecs[16] = '{1'b1, 1'b0, A_KIMASK,      32'h0,        32'h0};

        // Reset state and address decode
        repeat (3) tick();
        check("rst rdData", rdData, 32'h0);
        check("rst rdValid", 32'(rdValid), 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        addr = 32'hF000001F; #1;
        check("sel in window", 32'(sel), 32'd1);
        addr = 32'hF0000020; #1;
        check("sel above", 32'(sel), 32'd0);
        addr = 32'hE0000010; #1;
        check("sel high bits", 32'(sel), 32'd0);
        reset = 1'b1;
        repeat (4) tick();

        // Key 0 bounces with 2-cycle pulses, then a clean press
        addr = A_KDATA; rdEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            key_in[0] = bouncePat[i];
            tick();
            check($sformatf("t1 bounce %0d", i), rdData, 32'h0);
        end
        key_in[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t1 settle %0d", k), rdData, (k >= 7) ? 32'h1 : 32'h0);
        end
        rdEn = 1'b0;
        lastRead = 32'h1;
        tick();
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h1, "t1 kedge");

        // Switches and a key 1 press settle together; table read of SDATA lands right after
        sw_in = 10'h2A5;
        key_in[1] = 1'b0;
        repeat (6) tick();
        for (int v = 0; v < 17; v++) begin
            busOp(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].exp,
                  $sformatf("vec%0d", v));
        end

        // Key 2 press accepted on the same edge as a W1C of bit 2: the press wins
        key_in[2] = 1'b0;
        repeat (5) tick();
        addr = A_KEDGE; wrEn = 1'b1; wrData = 32'h4;
        tick();
        wrEn = 1'b0;
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h4, "t4 kedge");
        busOp(1'b1, 1'b0, A_KDATA, 32'h0, 32'h7, "t4 kdata");

        // Interrupt masking and latency
        busOp(1'b0, 1'b1, A_KEDGE, 32'hF, 32'h0, "t5 clr");
        busOp(1'b0, 1'b1, A_KIMASK, 32'h4, 32'h0, "t5 mask");
        key_in[1] = 1'b1; key_in[2] = 1'b1;
        repeat (8) tick();
        check("t5 irq idle", 32'(irq), 32'd0);
        key_in[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t5 key1 irq %0d", k), 32'(irq), 32'd0);
        end
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h2, "t5 kedge1");
        key_in[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t5 key2 irq %0d", k), 32'(irq), (k >= 7) ? 32'd1 : 32'd0);
        end
        addr = A_KEDGE; wrEn = 1'b1; wrData = 32'h4;
        tick();
        wrEn = 1'b0;
        check("t5 irq after clr", 32'(irq), 32'd1);
        tick();
        check("t5 irq drop", 32'(irq), 32'd0);
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h2, "t5 kedge left");

        // Unselected read, then reset in the middle of a key 3 debounce
        busOp(1'b1, 1'b0, 32'hF0000020, 32'h0, 32'h0, "t6 unsel");
        busOp(1'b0, 1'b1, A_KIMASK, 32'hF, 32'h0, "t6 mask");
        check("t6 irq pre", 32'(irq), 32'd1);
        key_in[3] = 1'b0;
        addr = A_KDATA; rdEn = 1'b1;
        repeat (3) tick();
        check("t6 pre rdData", rdData, 32'h7);
        check("t6 pre rdValid", 32'(rdValid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6 async rdData", rdData, 32'h0);
        check("t6 async rdValid", 32'(rdValid), 32'd0);
        check("t6 async irq", 32'(irq), 32'd0);
        rdEn = 1'b0;
        repeat (3) tick();
        check("t6 held irq", 32'(irq), 32'd0);
        reset = 1'b1;
        lastRead = 32'h0;
        repeat (20) tick();
        check("t6 post irq", 32'(irq), 32'd0);
        busOp(1'b1, 1'b0, A_KDATA, 32'h0, 32'hF, "t6 kdata");
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h0, "t6 kedge");
        busOp(1'b1, 1'b0, A_KIMASK, 32'h0, 32'h0, "t6 kimask");
        busOp(1'b1, 1'b0, A_SDATA, 32'h0, 32'h2A5, "t6 sdata");
        key_in[3] = 1'b1;
        repeat (8) tick();
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h0, "t6 release");
        key_in[3] = 1'b0;
        repeat (7) tick();
        busOp(1'b1, 1'b0, A_KEDGE, 32'h0, 32'h8, "t6 repress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
